// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding scoreboard.
//   TNEW_W / REG_W : Tnew field and register-number widths
//   FWD_*          : forward select encoding (RF, E, M, W)
//   stage_t        : per-stage producer entry {valid, wr, dst, tnew}
//   is_match       : producer/consumer match, $0 never matches
package fwd_pkg;

  localparam int unsigned TNEW_W = 2;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned SEL_W  = 2;

  localparam logic [SEL_W-1:0] FWD_RF = 2'd0;
  localparam logic [SEL_W-1:0] FWD_E  = 2'd1;
  localparam logic [SEL_W-1:0] FWD_M  = 2'd2;
  localparam logic [SEL_W-1:0] FWD_W  = 2'd3;

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [REG_W-1:0]  dst;
    logic [TNEW_W-1:0] tnew;
  } stage_t;

  function automatic logic is_match(input stage_t s, input logic [REG_W-1:0] src);
    return s.valid && s.wr && (s.dst == src) && (src != REG_W'(0));
  endfunction

endpackage

// File: rtl/fwd_pick.sv
// Combinational nearest-match forward selector for one consumer operand.
//   i_src        : consumer source register
//   i_e/i_m/i_w  : stage entries, nearest first (tie unused slots to zero)
//   o_sel        : FWD_RF/FWD_E/FWD_M/FWD_W
//   o_not_ready  : nearest producer still has tnew > 0
module fwd_pick
  import fwd_pkg::*;
(
  input  logic [REG_W-1:0] i_src,
  input  stage_t           i_e,
  input  stage_t           i_m,
  input  stage_t           i_w,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_not_ready
);

  // Nearest matching stage decides; older stages are ignored once one matches.
  always_comb begin
    o_sel       = FWD_RF;
    o_not_ready = 1'b0;
    if (is_match(i_e, i_src)) begin
      if (i_e.tnew == TNEW_W'(0)) o_sel = FWD_E;
      else                        o_not_ready = 1'b1;
    end else if (is_match(i_m, i_src)) begin
      if (i_m.tnew == TNEW_W'(0)) o_sel = FWD_M;
      else                        o_not_ready = 1'b1;
    end else if (is_match(i_w, i_src)) begin
      if (i_w.tnew == TNEW_W'(0)) o_sel = FWD_W;
      else                        o_not_ready = 1'b1;
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Producer scoreboard for the E/M/W stages of a 5-stage MIPS pipeline:
// tracks in-flight GPR writers, drives forward selects for D/E/M consumers
// and publishes the E/M producer view (dst, wr, Tnew) for the stall logic.
//   clk, rst_n           : clock, async active-low reset
//   stall, flush_e       : insert bubble into E this edge
//   d_wr/d_dst/d_tnew    : D-stage writer info; d_rs/d_rt D-stage sources
//   sel_*                : forward selects (0 RF, 1 E, 2 M, 3 W)
//   d_rs_busy/d_rt_busy  : nearest producer of D operand not ready
//   e_*/m_*              : per-stage producer view, zero for bubbles
//   hazard_err           : E or M consumer's nearest producer not ready
// Optional macro FWD_STATS_EN adds stall_cnt and fwd_cnt counters.
module fwd_scoreboard
  import fwd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush_e,
  input  logic              d_wr,
  input  logic [REG_W-1:0]  d_dst,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic [REG_W-1:0]  d_rs,
  input  logic [REG_W-1:0]  d_rt,
  output logic [SEL_W-1:0]  sel_d_rs,
  output logic [SEL_W-1:0]  sel_d_rt,
  output logic [SEL_W-1:0]  sel_e_rs,
  output logic [SEL_W-1:0]  sel_e_rt,
  output logic [SEL_W-1:0]  sel_m_rt,
  output logic              d_rs_busy,
  output logic              d_rt_busy,
  output logic              e_wr,
  output logic [REG_W-1:0]  e_dst,
  output logic [TNEW_W-1:0] e_tnew,
  output logic              m_wr,
  output logic [REG_W-1:0]  m_dst,
  output logic [TNEW_W-1:0] m_tnew,
  output logic              hazard_err
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fwd_cnt
`endif
);

  stage_t           r_e, r_m, r_w;
  logic [REG_W-1:0] r_e_rs, r_e_rt, r_m_rt;

  logic w_e_rs_nr, w_e_rt_nr, w_m_rt_nr;
  stage_t w_none;

  assign w_none = stage_t'('0);

  // Pipeline advance: M and W always move, E takes D unless bubbled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e    <= stage_t'('0);
      r_m    <= stage_t'('0);
      r_w    <= stage_t'('0);
      r_e_rs <= REG_W'(0);
      r_e_rt <= REG_W'(0);
      r_m_rt <= REG_W'(0);
    end else begin
      r_w      <= r_m;
      r_w.tnew <= TNEW_W'(0);
      r_m      <= r_e;
      r_m.tnew <= (r_e.tnew == TNEW_W'(0)) ? TNEW_W'(0) : TNEW_W'(r_e.tnew - TNEW_W'(1));
      r_m_rt   <= r_e_rt;
      if (stall || flush_e) begin
        r_e    <= stage_t'('0);
        r_e_rs <= REG_W'(0);
        r_e_rt <= REG_W'(0);
      end else begin
        r_e    <= '{valid: 1'b1, wr: d_wr, dst: d_dst, tnew: d_tnew};
        r_e_rs <= d_rs;
        r_e_rt <= d_rt;
      end
    end
  end

  fwd_pick u_pick_d_rs (.i_src(d_rs),   .i_e(r_e),    .i_m(r_m),    .i_w(r_w),
                        .o_sel(sel_d_rs), .o_not_ready(d_rs_busy));
  fwd_pick u_pick_d_rt (.i_src(d_rt),   .i_e(r_e),    .i_m(r_m),    .i_w(r_w),
                        .o_sel(sel_d_rt), .o_not_ready(d_rt_busy));
  fwd_pick u_pick_e_rs (.i_src(r_e_rs), .i_e(w_none), .i_m(r_m),    .i_w(r_w),
                        .o_sel(sel_e_rs), .o_not_ready(w_e_rs_nr));
  fwd_pick u_pick_e_rt (.i_src(r_e_rt), .i_e(w_none), .i_m(r_m),    .i_w(r_w),
                        .o_sel(sel_e_rt), .o_not_ready(w_e_rt_nr));
  fwd_pick u_pick_m_rt (.i_src(r_m_rt), .i_e(w_none), .i_m(w_none), .i_w(r_w),
                        .o_sel(sel_m_rt), .o_not_ready(w_m_rt_nr));

  assign hazard_err = w_e_rs_nr | w_e_rt_nr | w_m_rt_nr;

  // Producer view, gated so bubbles always read as zero.
  assign e_wr   = r_e.valid & r_e.wr;
  assign e_dst  = r_e.valid ? r_e.dst  : REG_W'(0);
  assign e_tnew = r_e.valid ? r_e.tnew : TNEW_W'(0);
  assign m_wr   = r_m.valid & r_m.wr;
  assign m_dst  = r_m.valid ? r_m.dst  : REG_W'(0);
  assign m_tnew = r_m.valid ? r_m.tnew : TNEW_W'(0);

`ifdef FWD_STATS_EN
  logic w_any_fwd;
  assign w_any_fwd = |{sel_d_rs, sel_d_rt, sel_e_rs, sel_e_rt, sel_m_rt};

  // Free-running event counters, wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'(0);
      fwd_cnt   <= 32'(0);
    end else begin
      if (stall)     stall_cnt <= stall_cnt + 32'(1);
      if (w_any_fwd) fwd_cnt   <= fwd_cnt + 32'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed self-checking bench for fwd_scoreboard.
module tb_fwd_scoreboard;
  import fwd_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall, flush_e, d_wr;
  logic [REG_W-1:0]  d_dst, d_rs, d_rt;
  logic [TNEW_W-1:0] d_tnew;
  logic [SEL_W-1:0]  sel_d_rs, sel_d_rt, sel_e_rs, sel_e_rt, sel_m_rt;
  logic              d_rs_busy, d_rt_busy, e_wr, m_wr, hazard_err;
  logic [REG_W-1:0]  e_dst, m_dst;
  logic [TNEW_W-1:0] e_tnew, m_tnew;
`ifdef FWD_STATS_EN
  logic [31:0]       stall_cnt, fwd_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush_e(flush_e),
    .d_wr(d_wr), .d_dst(d_dst), .d_tnew(d_tnew), .d_rs(d_rs), .d_rt(d_rt),
    .sel_d_rs(sel_d_rs), .sel_d_rt(sel_d_rt), .sel_e_rs(sel_e_rs),
    .sel_e_rt(sel_e_rt), .sel_m_rt(sel_m_rt),
    .d_rs_busy(d_rs_busy), .d_rt_busy(d_rt_busy),
    .e_wr(e_wr), .e_dst(e_dst), .e_tnew(e_tnew),
    .m_wr(m_wr), .m_dst(m_dst), .m_tnew(m_tnew),
    .hazard_err(hazard_err)
`ifdef FWD_STATS_EN
    , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_d(input logic wr, input int dst, input int tnew, input int rs, input int rt);
    d_wr   = wr;
    d_dst  = REG_W'(dst);
    d_tnew = TNEW_W'(tnew);
    d_rs   = REG_W'(rs);
    d_rt   = REG_W'(rt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    set_d(1'b0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush_e = 1'b0;
    set_d(1'b0, 0, 0, 0, 0);
    #12;
    chk("rst_e_wr", 32'(e_wr), 32'd0);
    chk("rst_m_wr", 32'(m_wr), 32'd0);
    chk("rst_sel_d_rs", 32'(sel_d_rs), 32'd0);
    chk("rst_hazard", 32'(hazard_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Dependent addu: ALU writer of $8 then consumer of $8.
    set_d(1'b1, 8, 1, 0, 0);
    tick();
    set_d(1'b0, 0, 0, 8, 0);
    #1;
    chk("alu_e_view_wr", 32'(e_wr), 32'd1);
    chk("alu_e_view_dst", 32'(e_dst), 32'd8);
    chk("alu_e_view_tnew", 32'(e_tnew), 32'd1);
    chk("alu_sel_d_rs", 32'(sel_d_rs), 32'd0);
    chk("alu_d_rs_busy", 32'(d_rs_busy), 32'd1);
    tick();
    chk("alu_sel_e_rs", 32'(sel_e_rs), 32'd2);
    chk("alu_hazard", 32'(hazard_err), 32'd0);
    chk("alu_m_dst", 32'(m_dst), 32'd8);
    chk("alu_m_tnew", 32'(m_tnew), 32'd0);
    drain();

    // lw then use, with one stall edge.
    set_d(1'b1, 9, 2, 0, 0);
    tick();
    set_d(1'b0, 0, 0, 0, 9);
    #1;
    chk("lw_d_rt_busy0", 32'(d_rt_busy), 32'd1);
    stall = 1'b1;
    tick();
    stall = 1'b0;
    chk("lw_stall_e_wr", 32'(e_wr), 32'd0);
    chk("lw_m_tnew", 32'(m_tnew), 32'd1);
    chk("lw_d_rt_busy1", 32'(d_rt_busy), 32'd1);
    chk("lw_sel_d_rt1", 32'(sel_d_rt), 32'd0);
    tick();
    chk("lw_sel_d_rt_w", 32'(sel_d_rt), 32'd3);
    chk("lw_d_rt_busy2", 32'(d_rt_busy), 32'd0);
    chk("lw_sel_e_rt_w", 32'(sel_e_rt), 32'd3);
    drain();

    // Priority: E (lui, ready) beats M, both writing $4.
    set_d(1'b1, 4, 1, 0, 0);
    tick();
    set_d(1'b1, 4, 0, 0, 0);
    tick();
    set_d(1'b0, 0, 0, 4, 0);
    #1;
    chk("prio_sel_d_rs_e", 32'(sel_d_rs), 32'd1);
    chk("prio_busy_e", 32'(d_rs_busy), 32'd0);
    // Nearest producer not ready hides a ready older one.
    set_d(1'b1, 4, 2, 0, 0);
    tick();
    set_d(1'b0, 0, 0, 4, 0);
    #1;
    chk("prio_sel_d_rs_blk", 32'(sel_d_rs), 32'd0);
    chk("prio_busy_blk", 32'(d_rs_busy), 32'd1);
    drain();

    // $0 writer never forwards.
    set_d(1'b1, 0, 0, 0, 0);
    tick();
    #1;
    chk("r0_e_wr", 32'(e_wr), 32'd1);
    chk("r0_sel_d_rs", 32'(sel_d_rs), 32'd0);
    chk("r0_busy", 32'(d_rs_busy), 32'd0);
    drain();

    // Store data: ALU writes $5, sw rt=5 reaches M while writer is in W.
    set_d(1'b1, 5, 1, 0, 0);
    tick();
    set_d(1'b0, 0, 0, 0, 5);
    #1;
    chk("st_d_rt_busy", 32'(d_rt_busy), 32'd1);
    tick();
    set_d(1'b0, 0, 0, 0, 0);
    #1;
    chk("st_sel_e_rt", 32'(sel_e_rt), 32'd2);
    tick();
    chk("st_sel_m_rt", 32'(sel_m_rt), 32'd3);
    chk("st_hazard", 32'(hazard_err), 32'd0);
    drain();

    // Missed load-use: E consumer sees M with tnew>0.
    set_d(1'b1, 6, 2, 0, 0);
    tick();
    set_d(1'b0, 0, 0, 6, 0);
    tick();
    chk("miss_hazard", 32'(hazard_err), 32'd1);
    chk("miss_sel_e_rs", 32'(sel_e_rs), 32'd0);
    drain();

    // flush_e alone, and flush with stall, both bubble E.
    set_d(1'b1, 7, 0, 0, 0);
    flush_e = 1'b1;
    tick();
    chk("flush_e_wr", 32'(e_wr), 32'd0);
    chk("flush_e_dst", 32'(e_dst), 32'd0);
    stall = 1'b1;
    tick();
    chk("flush_stall_e_wr", 32'(e_wr), 32'd0);
    stall = 1'b0; flush_e = 1'b0;
    drain();

    // Reset mid-flight with three writers in E/M/W.
    set_d(1'b1, 10, 0, 0, 0);
    tick();
    set_d(1'b1, 11, 0, 0, 0);
    tick();
    set_d(1'b1, 12, 0, 0, 0);
    tick();
    set_d(1'b0, 0, 0, 11, 10);
    #1;
    chk("pre_rst_sel_d_rs", 32'(sel_d_rs), 32'd2);
    chk("pre_rst_sel_d_rt", 32'(sel_d_rt), 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sel_d_rs", 32'(sel_d_rs), 32'd0);
    chk("mid_rst_sel_d_rt", 32'(sel_d_rt), 32'd0);
    chk("mid_rst_e_wr", 32'(e_wr), 32'd0);
    chk("mid_rst_e_dst", 32'(e_dst), 32'd0);
    chk("mid_rst_m_wr", 32'(m_wr), 32'd0);
    chk("mid_rst_m_dst", 32'(m_dst), 32'd0);
`ifdef FWD_STATS_EN
    chk("mid_rst_stall_cnt", stall_cnt, 32'd0);
    chk("mid_rst_fwd_cnt", fwd_cnt, 32'd0);
`endif
    set_d(1'b0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
`ifdef FWD_STATS_EN
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    chk("stat_stall_cnt", stall_cnt, 32'd3);
    chk("stat_fwd_cnt", fwd_cnt, 32'd0);
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Tracks in-flight register writers through the E/M/W stages of the 5-stage MIPS pipeline.
- Holds each writer's destination number and Tnew countdown.
- Drives operand forwarding selects for D, E and M consumers.
- Publishes the per-stage producer view (dst, write-enable, Tnew) that the stall logic compares against Tuse. This makes it the producer side of the Tuse/Tnew interface.

Parameters:
- TNEW_W, 2, width of Tnew field
- REG_W, 5, register number width

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  D held, bubble into E this edge
- flush_e  in  1  force bubble into E, independent of stall
- d_wr  in  1  D-stage instr writes a GPR
- d_dst  in  REG_W  D-stage destination register
- d_tnew  in  TNEW_W  D-stage instr Tnew at E entry (0 lui/jal, 1 ALU, 2 lw)
- d_rs  in  REG_W  D-stage rs used (0 if unused)
- d_rt  in  REG_W  D-stage rt used (0 if unused)
- sel_d_rs, sel_d_rt  out  2  forward select for D operands
- sel_e_rs, sel_e_rt  out  2  forward select for E operands
- sel_m_rt  out  2  forward select for M store data
- d_rs_busy, d_rt_busy  out  1  nearest producer of D operand not yet ready
- e_wr, e_dst, e_tnew  out  1/REG_W/TNEW_W  E-stage producer view
- m_wr, m_dst, m_tnew  out  1/REG_W/TNEW_W  M-stage producer view
- hazard_err  out  1  E or M consumer's nearest producer not ready (stall logic missed it)

Behaviour:
- Three stage entries: E, M, W. Each holds valid, wr, dst, tnew; E additionally holds rs/rt, M holds rt.
- Reset: all entries cleared (valid=0, fields 0), so every output is 0.
- Each posedge, W<=M, M<=E, and E<=D or bubble:
  - stall or flush_e: E<=bubble (valid=0).
  - Otherwise: E<={1, d_wr, d_dst, d_tnew, d_rs, d_rt}.
  - M and W always advance; stall never freezes them.
- Tnew decrements on each advance, saturating at 0: M.tnew = max(E.tnew-1, 0); W.tnew is forced to 0.
- Producer match: stage valid && wr && dst==src && src!=0. Register $0 never matches.
- Select encoding: 0 RF, 1 E, 2 M, 3 W.
- Nearest-match priority. Candidates per consumer:
  - D: E, M, W
  - E: M, W
  - M: W only
- The nearest matching stage decides the result. An older stage is never used when a nearer stage matches.
  - Nearest producer has tnew==0: sel = that stage, busy=0.
  - Nearest producer has tnew>0: sel=0; busy=1 for D operands, hazard_err=1 for E/M operands.
  - No match: sel=0, busy=0.
- All selects, busy, hazard_err and the producer-view outputs are combinational from stage state plus the d_* inputs, valid in the same cycle.
- e_wr/m_wr = valid&&wr. The view is zeroed for bubbles.
- Simultaneous stall and flush_e: identical to stall.
- Async reset mid-operation clears all entries immediately. There is no partial state.

Optional Feature:
- FWD_STATS_EN defined: adds outputs stall_cnt[31:0] and fwd_cnt[31:0].
  - stall_cnt increments on each cycle with stall=1.
  - fwd_cnt increments each cycle in which any sel_* is nonzero.
  - Both wrap at 2^32 and are cleared by rst_n.
- FWD_STATS_EN undefined: neither port nor counters exist.

Decomposition:
- Package fwd_pkg holds:
  - FWD_RF/FWD_E/FWD_M/FWD_W select constants
  - TNEW_W, REG_W
  - the stage-entry struct {valid, wr, dst, tnew}
- One sub-module, fwd_pick: a combinational nearest-match selector.
  - Takes a source register and up to three stage entries.
  - Returns sel and not_ready.
  - Instantiated once per consumer operand.

Test Plan:
- Dependent addu, no stall: d_wr=1,d_dst=8,d_tnew=1 clocked, then next D has d_rs=8 → sel_d_rs=0 with d_rs_busy=1 (E tnew=1). After one more edge: sel_e_rs=2 (M), hazard_err=0.
- lw then use: d_tnew=2,d_dst=9; next D d_rt=9 → d_rt_busy=1. Apply stall one edge → E bubble, M.tnew=1, busy still 1. Next edge → W has 9, sel_d_rt=3, busy=0.
- Priority: E writes $4 (tnew 0, lui), M also writes $4 → sel_d_rs=1 (E), not 2.
- $0 writer: d_dst=0,d_wr=1 clocked, consumer d_rs=0 → sel=0, busy=0.
- Store data: ALU writes $5 reaches W while sw with rt=5 sits in M → sel_m_rt=3.
- Reset mid-flight: three writers in E/M/W, drop rst_n asynchronously → all sel/busy/view outputs 0 before next clk edge. With FWD_STATS_EN, counters read 0.
